// File: rtl/line_buff_fill.sv
// Line-buffer fill responder: copies one tile row from the frame buffer into line buffer A or B
// and pulses done for that buffer. It tracks the current tile row and wraps it once per frame.
module line_buff_fill #(
    parameter int unsigned TILE_PER_LINE    = 160,
    parameter int unsigned TILE_ROWS        = 120,
    parameter int unsigned DATA_WIDTH       = 12,
    parameter int unsigned TILE_CTR_WIDTH   = $clog2(TILE_PER_LINE),
    parameter int unsigned FBUFF_ADDR_WIDTH = $clog2(TILE_PER_LINE * TILE_ROWS)
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic [1:0]                  buff_fill_req_i,
    output logic [1:0]                  buff_fill_done_o,
    output logic                        fbuff_rd_en_o,
    output logic [FBUFF_ADDR_WIDTH-1:0] fbuff_addr_o,
    input  logic [DATA_WIDTH-1:0]       fbuff_data_i,
    output logic [1:0]                  lbuff_wr_en_o,
    output logic [TILE_CTR_WIDTH-1:0]   lbuff_addr_o,
    output logic [DATA_WIDTH-1:0]       lbuff_data_o,
    output logic                        busy_o,
    output logic                        req_err_o
);

    localparam int unsigned RowWidth = (TILE_ROWS > 1) ? $clog2(TILE_ROWS) : 1;
    localparam logic [TILE_CTR_WIDTH-1:0]   LastCol  = TILE_CTR_WIDTH'(TILE_PER_LINE - 1);
    localparam logic [RowWidth-1:0]         LastRow  = RowWidth'(TILE_ROWS - 1);
    localparam logic [FBUFF_ADDR_WIDTH-1:0] LineStep = FBUFF_ADDR_WIDTH'(TILE_PER_LINE);

    typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

    state_e                      state_q;
    logic [1:0]                  target_q;
    logic [TILE_CTR_WIDTH-1:0]   col_q;
    logic [RowWidth-1:0]         row_q;
    logic [FBUFF_ADDR_WIDTH-1:0] row_base_q;
    logic [1:0]                  done_q;
    logic                        rd_en_q;
    logic [FBUFF_ADDR_WIDTH-1:0] fbuff_addr_q;
    logic [1:0]                  wr_en_q;
    logic [TILE_CTR_WIDTH-1:0]   lbuff_addr_q;
    logic                        busy_q;
    logic                        req_err_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= StIdle;
            target_q     <= 2'b00;
            col_q        <= '0;
            row_q        <= '0;
            row_base_q   <= '0;
            done_q       <= 2'b00;
            rd_en_q      <= 1'b0;
            fbuff_addr_q <= '0;
            wr_en_q      <= 2'b00;
            lbuff_addr_q <= '0;
            busy_q       <= 1'b0;
            req_err_q    <= 1'b0;
        end else begin
            // Write stage trails the read stage by one cycle, matching the RAM read latency.
            wr_en_q      <= rd_en_q ? target_q : 2'b00;
            lbuff_addr_q <= col_q;
            if (state_q != StIdle && buff_fill_req_i != 2'b00) begin
                req_err_q <= 1'b1;
            end
            case (state_q)
                StIdle: begin
                    if (buff_fill_req_i == 2'b01 || buff_fill_req_i == 2'b10) begin
                        target_q     <= buff_fill_req_i;
                        col_q        <= '0;
                        fbuff_addr_q <= row_base_q;
                        rd_en_q      <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= StRead;
                    end else if (buff_fill_req_i == 2'b11) begin
                        req_err_q <= 1'b1;
                    end
                end
                StRead: begin
                    if (col_q == LastCol) begin
                        rd_en_q <= 1'b0;
                        state_q <= StDrain;
                    end else begin
                        col_q        <= col_q + TILE_CTR_WIDTH'(1);
                        fbuff_addr_q <= fbuff_addr_q + FBUFF_ADDR_WIDTH'(1);
                    end
                end
                StDrain: begin
                    done_q  <= target_q;
                    state_q <= StDone;
                end
                StDone: begin
                    done_q  <= 2'b00;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                    if (row_q == LastRow) begin
                        row_q      <= '0;
                        row_base_q <= '0;
                    end else begin
                        row_q      <= row_q + RowWidth'(1);
                        row_base_q <= row_base_q + LineStep;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign buff_fill_done_o = done_q;
    assign fbuff_rd_en_o    = rd_en_q;
    assign fbuff_addr_o     = fbuff_addr_q;
    assign lbuff_wr_en_o    = wr_en_q;
    assign lbuff_addr_o     = lbuff_addr_q;
    // Data comes straight off the frame-buffer output register; masked so it idles at zero.
    assign lbuff_data_o     = fbuff_data_i & {DATA_WIDTH{|wr_en_q}};
    assign busy_o           = busy_q;
    assign req_err_o        = req_err_q;

endmodule

// File: tb/tb_line_buff_fill.sv
// Directed bench for line_buff_fill: frame-buffer RAM model, line-buffer capture model and
// per-fill timing/address/content checks with immediate assertions.
module tb_line_buff_fill;

    logic        clk;
    logic        rstn;
    logic [1:0]  req;
    logic [1:0]  done;
    logic        rd_en;
    logic [14:0] fb_addr;
    logic [11:0] fb_data;
    logic [1:0]  wr_en;
    logic [7:0]  lb_addr;
    logic [11:0] lb_data;
    logic        busy;
    logic        req_err;

    logic [11:0] lb_a [256];
    logic [11:0] lb_b [256];

    int n_tests = 0;
    int n_fail  = 0;

    line_buff_fill dut (
        .clk_i            (clk),
        .rstn_i           (rstn),
        .buff_fill_req_i  (req),
        .buff_fill_done_o (done),
        .fbuff_rd_en_o    (rd_en),
        .fbuff_addr_o     (fb_addr),
        .fbuff_data_i     (fb_data),
        .lbuff_wr_en_o    (wr_en),
        .lbuff_addr_o     (lb_addr),
        .lbuff_data_o     (lb_data),
        .busy_o           (busy),
        .req_err_o        (req_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] fword(input int a);
        int v;
        v = a * 37 + (a >> 4) + 5;
        return v[11:0];
    endfunction

    // Synchronous-read frame buffer with one cycle of latency.
    always @(posedge clk) if (rd_en) fb_data <= fword(int'(fb_addr));

    always @(posedge clk) begin
        if (wr_en[0]) lb_a[lb_addr] <= lb_data;
        if (wr_en[1]) lb_b[lb_addr] <= lb_data;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Output registered at edge E+j is observed at j; a request sampled at E gives reads at
    // j=0..159, writes at j=1..160, done at j=161 and busy low from j=162.
    task automatic do_fill(input logic [1:0] tgt, input int base, input string tag,
                           input int inject);
        int rd_n, rd_bad, wr_n, wr_bad, done_n, done_at, busy_bad, lb_bad;
        logic [1:0] done_val;
        rd_n = 0; rd_bad = 0; wr_n = 0; wr_bad = 0; done_n = 0; done_at = -1;
        busy_bad = 0; lb_bad = 0; done_val = 2'b00;
        req = tgt;
        for (int j = 0; j <= 163; j++) begin
            @(posedge clk);
            #1;
            if (rd_en) begin
                rd_n++;
                if (j > 159 || int'(fb_addr) != base + j) rd_bad++;
            end
            if (wr_en != 2'b00) begin
                wr_n++;
                if (wr_en != tgt || j < 1 || j > 160 || int'(lb_addr) != j - 1) wr_bad++;
            end
            if (done != 2'b00) begin
                done_n++;
                done_at  = j;
                done_val = done;
            end
            if (busy !== (j <= 161)) busy_bad++;
            req = (j == inject) ? 2'b10 : 2'b00;
        end
        for (int i = 0; i < 160; i++) begin
            if ((tgt[0] ? lb_a[i] : lb_b[i]) !== fword(base + i)) lb_bad++;
        end
        chk({tag, ".rd_cycles"}, rd_n, 160);
        chk({tag, ".rd_addr_bad"}, rd_bad, 0);
        chk({tag, ".wr_cycles"}, wr_n, 160);
        chk({tag, ".wr_bad"}, wr_bad, 0);
        chk({tag, ".done_count"}, done_n, 1);
        chk({tag, ".done_at"}, done_at, 161);
        chk({tag, ".done_val"}, done_val, tgt);
        chk({tag, ".busy_bad"}, busy_bad, 0);
        chk({tag, ".lb_data_bad"}, lb_bad, 0);
    endtask

    initial begin
        int act;
        rstn = 1'b0;
        req  = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.outputs", {done, rd_en, fb_addr, wr_en, lb_addr, lb_data, busy, req_err}, 64'd0);
        chk("rst.busy", busy, 1'b0);
        chk("rst.req_err", req_err, 1'b0);
        rstn = 1'b1;
        repeat (6) @(posedge clk);
        #1;

        do_fill(2'b01, 0, "fill0", -1);
        do_fill(2'b10, 160, "fill1", -1);
        for (int n = 2; n <= 120; n++) begin
            do_fill((n % 2 == 0) ? 2'b01 : 2'b10, (n % 120) * 160, $sformatf("fill%0d", n), -1);
        end
        chk("err.clean", req_err, 1'b0);

        // Request for B in the middle of an A fill.
        do_fill(2'b01, 160, "inject", 50);
        chk("err.set", req_err, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        chk("err.sticky", req_err, 1'b1);

        rstn = 1'b0;
        #2;
        chk("rst2.outputs", {done, rd_en, fb_addr, wr_en, lb_addr, lb_data, busy, req_err}, 64'd0);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Both buffers requested at once while idle.
        req = 2'b11;
        act = 0;
        for (int j = 0; j < 6; j++) begin
            @(posedge clk);
            #1;
            req = 2'b00;
            if (rd_en || wr_en != 2'b00 || busy || done != 2'b00) act++;
        end
        chk("req11.activity", act, 0);
        chk("req11.err", req_err, 1'b1);

        // Reset during read index 80.
        req = 2'b01;
        @(posedge clk);
        #1;
        req = 2'b00;
        for (int j = 1; j <= 80; j++) begin
            @(posedge clk);
            #1;
        end
        chk("midrst.pre_rd_en", rd_en, 1'b1);
        chk("midrst.pre_addr", fb_addr, 15'd80);
        #3;
        rstn = 1'b0;
        #1;
        chk("midrst.outputs", {done, rd_en, fb_addr, wr_en, lb_addr, lb_data, busy, req_err},
            64'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        act = 0;
        for (int j = 0; j < 4; j++) begin
            @(posedge clk);
            #1;
            if (done != 2'b00 || rd_en || busy) act++;
        end
        chk("midrst.no_done", act, 0);
        do_fill(2'b01, 0, "post_rst", -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
